// File: rtl/logic_unit_pkg.sv
// Shared types for the logic-unit arbiter: operation encoding and FSM states.
package logic_unit_pkg;

  typedef enum logic {
    OP_AND = 1'b0,
    OP_XOR = 1'b1
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/logic_alu.sv
// Shared bitwise unit: y = a & b or a ^ b.
// Purely combinational; no carry between bit positions.
module logic_alu
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = (op == OP_XOR) ? (a ^ b) : (a & b);

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one logic unit among NUM_REQ requesters; IDLE/EXEC/RESP, one op per 3 cycles.
// Result is held on rsp_* until rsp_ready; no new grant while a response is pending.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [CNT_W-1:0]           done_count
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int SW   = ID_W + 1;

  typedef logic [ID_W-1:0] id_t;

  localparam id_t LAST_ID = id_t'(NUM_REQ - 1);

  // First valid requester at or above ptr, wrapping past NUM_REQ-1 back to 0.
  function automatic id_t rr_pick(input logic [NUM_REQ-1:0] vld, input id_t ptr);
    logic [SW-1:0] sum;
    id_t           idx;
    id_t           pick;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!found && vld[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  arb_state_t       state_q, state_d;
  id_t              rr_ptr_q, rr_ptr_d;
  id_t              grant_q, grant_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  id_t              rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;

  id_t              pick;
  logic [WIDTH-1:0] alu_y;

  assign pick = rr_pick(req_valid, rr_ptr_q);

  logic_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    done_count_d = done_count_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[pick] = 1'b1;
          grant_d         = pick;
          op_d            = op_t'(req_op[pick]);
          a_d             = req_a[pick*WIDTH +: WIDTH];
          b_d             = req_b[pick*WIDTH +: WIDTH];
          state_d         = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_y;
        rsp_id_d    = grant_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // The pointer moves past the owner only once its result has been taken.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
          if (done_count_q != '1) begin
            done_count_d = done_count_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      done_count_q <= done_count_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a cycle-level reference model checked every negedge.
module tb_logic_unit_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic [CW-1:0]  done_count;

  logic_unit_arbiter #(
    .NUM_REQ(N),
    .WIDTH  (W),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .done_count(done_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: stage 0 = waiting for a request, 1 = result being computed,
  // 2 = result on offer. The result is computed directly from the spec formula.
  int           m_stage = 0;
  int           m_ptr   = 0;
  int           m_grant = 0;
  int           m_cnt   = 0;
  int           m_g     = 0;
  int           c_g     = 0;
  logic [W-1:0] m_res   = '0;
  logic [N-1:0] exp_rdy;

  function automatic int rr_first(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_stage = 0;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_stage == 0) begin
      m_g = rr_first(req_valid, m_ptr);
      if (m_g >= 0) begin
        m_grant = m_g;
        m_res   = req_op[m_g] ? (req_a[m_g*W +: W] ^ req_b[m_g*W +: W])
                              : (req_a[m_g*W +: W] & req_b[m_g*W +: W]);
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      m_stage = 2;
    end else if (rsp_ready) begin
      m_ptr   = (m_grant + 1) % N;
      m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      m_stage = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_done_count", done_count, 0);
    end else begin
      exp_rdy = '0;
      if (m_stage == 0) begin
        c_g = rr_first(req_valid, m_ptr);
        if (c_g >= 0) exp_rdy[c_g] = 1'b1;
      end
      check("model_req_ready", req_ready, exp_rdy);
      check("model_rsp_valid", rsp_valid, m_stage == 2);
      if (m_stage == 2) begin
        check("model_rsp_id", rsp_id, m_grant);
        check("model_rsp_data", rsp_data, m_res);
      end
      check("model_done_count", done_count, m_cnt);
    end
  end

  task automatic wait_ready(input int idx, input string nm);
    int n = 0;
    @(negedge clk);
    while (req_ready[idx] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, req_ready[idx], 1);
  endtask

  task automatic wait_rsp(input string nm);
    int n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(nm, rsp_valid, 1);
  endtask

  task automatic single(input int idx, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_d, input string nm);
    @(posedge clk); #1;
    req_valid[idx]     = 1'b1;
    req_op[idx]        = op;
    req_a[idx*W +: W]  = a;
    req_b[idx*W +: W]  = b;
    wait_ready(idx, {nm, "_ready"});
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    @(negedge clk);
    check({nm, "_lat_exec"}, rsp_valid, 0);
    @(negedge clk);
    check({nm, "_lat_resp"}, rsp_valid, 1);
    check({nm, "_id"}, rsp_id, idx);
    check({nm, "_data"}, rsp_data, exp_d);
  endtask

  int exp_ids [5] = '{0, 1, 2, 3, 0};

  initial begin
    int k;
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_done_count", done_count, 0);
    check("reset_rsp_valid", rsp_valid, 0);

    single(0, 1'b0, 8'hF0, 8'h3C, 8'h30, "and_req0");
    @(negedge clk);
    check("and_count", done_count, 1);

    single(2, 1'b1, 8'hAA, 8'hFF, 8'h55, "xor_req2");
    @(negedge clk);
    check("xor_count", done_count, 2);

    // rr_ptr is 3 here; reset while the granted op sits in EXEC.
    @(posedge clk); #1;
    req_valid = 4'b1111;
    req_op    = 4'b0000;
    wait_ready(3, "rst_grant3");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", rsp_valid, 0);
    check("rst_mid_count", done_count, 0);
    check("rst_mid_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_next_grant", req_ready, 4'b0001);

    k = 0;
    n = 0;
    while (k < 5 && n < 100) begin
      if (rsp_valid === 1'b1) begin
        check("rr_id", rsp_id, exp_ids[k]);
        k++;
      end
      if (k < 5) begin
        @(negedge clk);
        n++;
      end
    end
    check("rr_responses", k, 5);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("rr_count", done_count, 5);

    // Backpressure: rr_ptr=1, requesters 1 and 2 valid.
    @(posedge clk); #1;
    req_valid        = 4'b0110;
    req_op           = 4'b0010;
    req_a[1*W +: W]  = 8'h0F;
    req_b[1*W +: W]  = 8'h33;
    req_a[2*W +: W]  = 8'hC3;
    req_b[2*W +: W]  = 8'h5A;
    wait_ready(1, "bp_grant1");
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rsp_ready    = 1'b0;
    wait_rsp("bp_rsp");
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 1);
      check("bp_data", rsp_data, 8'h3C);
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_release_done", rsp_valid, 0);
    check("bp_next_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp("bp_rsp2");
    check("bp_rsp2_id", rsp_id, 2);
    check("bp_rsp2_data", rsp_data, 8'h42);
    @(negedge clk);
    check("bp_count", done_count, 7);

    // Wrap + skip: rr_ptr=3, only requester 1 valid.
    @(posedge clk); #1;
    req_valid        = 4'b0010;
    req_op           = 4'b0000;
    req_a[1*W +: W]  = 8'hFF;
    req_b[1*W +: W]  = 8'h81;
    @(negedge clk);
    check("wrap_grant1", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp("wrap_rsp");
    check("wrap_id", rsp_id, 1);
    check("wrap_data", rsp_data, 8'h81);
    @(posedge clk); #1 req_valid = 4'b0110;
    @(negedge clk);
    check("wrap_next_ptr", req_ready, 4'b0100);
    check("sat_count", done_count, CNT_MAX);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp("sat_rsp");
    @(negedge clk);
    check("sat_hold", done_count, CNT_MAX);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
